multi_alarm_clock: RTL and testbench
====================================

MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, which is the clk cycles per second.
REQ-002 SHALL have parameter NUM_ALARMS, default 4, which is the number of alarm slots (range 1..16).
REQ-003 SHALL have parameter SNOOZE_MIN, default 5, which is the snooze length in minutes (range 1..59).
REQ-004 SHALL have parameter RING_TIMEOUT_MIN, default 2, which is the minutes of ringing before auto-stop (range 1..59).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port run, input, 1 bit: time advances while 1.
REQ-008 SHALL have port mode_12h, input, 1 bit: 1 selects 12-hour display, 0 selects 24-hour display.
REQ-009 SHALL have ports min_up, min_down, hour_up, hour_down, input, 1 bit each: single-cycle debounced adjust pulses.
REQ-010 SHALL have port alarm_sel, input, $clog2(NUM_ALARMS) bits (minimum 1): the alarm slot index.
REQ-011 SHALL have port alarm_load, input, 1 bit: pulse that copies current hh:mm into slot alarm_sel.
REQ-012 SHALL have port alarm_en, input, NUM_ALARMS bits: per-slot enable.
REQ-013 SHALL have ports snooze and dismiss, input, 1 bit each: single-cycle pulses.
REQ-014 SHALL have port time_bcd, output, 24 bits: {hh,mm,ss} as six BCD digits, in display mode.
REQ-015 SHALL have port pm, output, 1 bit: 1 when mode_12h=1 and internal hour >= 12; otherwise 0.
REQ-016 SHALL have port ringing, output, 1 bit: high while the FSM is in RINGING.
REQ-017 SHALL have port ring_src, output, $clog2(NUM_ALARMS) bits (minimum 1): the slot that caused the current ring or snooze.
REQ-018 SHALL have port sec_tick, output, 1 bit: one-cycle pulse per elapsed second.

Function
REQ-019 SHALL run a prescaler that counts 0..CLK_HZ-1 while run=1, asserts sec_tick on count CLK_HZ-1, and holds its value (no clear) while run=0.
REQ-020 SHALL keep internal time as 24-hour BCD; on sec_tick, ss increments with carry 59->00 into mm, mm 59->00 carries into hh, and hh 23->00 wraps.
REQ-021 SHALL apply min_up/min_down as mm +/-1 with wrap (59<->00), no carry into hh, ss unchanged.
REQ-022 SHALL apply hour_up/hour_down as hh +/-1 with wrap (23<->00).
REQ-023 SHALL latch an adjust pulse arriving in a sec_tick cycle into a pending flag and apply it on the next cycle, so no press is lost; up and down on the same field in the same cycle cancel.
REQ-024 SHALL display in 12-hour mode as: internal 00 -> 12, 13..23 -> 01..11, other hours unchanged. The mode change is combinational on time_bcd and pm only.
REQ-025 SHALL store per slot a 16-bit hh:mm in 24-hour BCD; alarm_load writes the current hh:mm into slot alarm_sel; a load with alarm_sel >= NUM_ALARMS is ignored.
REQ-026 SHALL trigger only in a sec_tick cycle whose next time is hh:mm:00 and equals an enabled slot. Adjusts never trigger. If several slots match, the lowest index wins.
REQ-027 SHALL implement FSM states IDLE, RINGING, SNOOZE with these transitions:
- IDLE -> RINGING on trigger: ring_src is loaded and the ring timer is loaded with RING_TIMEOUT_MIN*60 s.
- RINGING -> SNOOZE on snooze: the snooze timer is loaded with SNOOZE_MIN*60 s.
- RINGING -> IDLE on dismiss, or when the ring timer reaches 0.
- SNOOZE -> RINGING when the snooze timer reaches 0; the ring timer is reloaded.
- SNOOZE -> IDLE on dismiss.
- SNOOZE -> RINGING on a new trigger; ring_src is updated.
REQ-028 SHALL give dismiss priority over snooze when both arrive in the same cycle; a trigger while RINGING is ignored.
REQ-029 SHALL decrement the ring and snooze timers only on sec_tick, so they freeze while run=0; snooze/dismiss remain effective while run=0.
REQ-030 SHALL assert ringing on the same clock edge at which time becomes hh:mm:00 for a trigger (zero added latency).

Reset
REQ-031 SHALL, on reset=0, asynchronously set: prescaler 0, time 00:00:00, all alarm slots 00:00, pending flags 0, FSM IDLE, both timers 0, ring_src 0, sec_tick 0.
REQ-032 SHALL return all outputs to their reset values immediately when reset is asserted mid-ring or mid-snooze; with mode_12h=1 time_bcd then shows 12:00:00 and pm=0.

Structure
REQ-033 SHALL take ring_state_t (IDLE/RINGING/SNOOZE) and the BCD limit constants (59, 23, 12) from the shared package clock_pkg.
REQ-034 SHALL instantiate one sub-module, bcd_time_counter (tick, adjust pulses, 24-bit 24-hour BCD out); the prescaler, alarm bank and FSM stay in the top.

Verification
REQ-035 SHALL cover: CLK_HZ=10, run=1 from 23:59:58, 20 cycles -> 00:00:00; sec_tick exactly twice.
REQ-036 SHALL cover: min_up in the same cycle as a sec_tick at 10:59:59 -> 11:00:00, then 11:01:00 one cycle later.
REQ-037 SHALL cover: mode_12h=1 at internal 00:30:00 -> 12:30:00, pm=0; at 13:05:00 -> 01:05:00, pm=1.
REQ-038 SHALL cover: slots 1 and 2 both 07:00, both enabled, time 06:59:59, tick -> ringing=1 on the 07:00:00 edge, ring_src=1.
REQ-039 SHALL cover: RINGING + snooze (SNOOZE_MIN=1) -> ringing=0, re-rings after exactly 60 ticks; snooze+dismiss same cycle -> IDLE.
REQ-040 SHALL cover: reset asserted during RINGING -> ringing=0 and time_bcd=00:00:00 without waiting for a clk edge.

Source files
------------

// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared types and BCD helpers for the multi-alarm clock.
//   ring_state_t   : alarm FSM states (IDLE / RINGING / SNOOZE)
//   BCD_MAX_MIN    : 59, upper limit for minutes and seconds
//   BCD_MAX_HOUR   : 23, upper limit for 24-hour hours
//   BCD_NOON       : 12, first afternoon hour / midnight display value
//   bcd_inc/bcd_dec: two-digit BCD +/-1 with wrap at a given limit
//   hour_to_12h    : 24-hour BCD hour -> 12-hour BCD display hour
// ---------------------------------------------------------------------------
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } ring_state_t;

  localparam logic [7:0] BCD_MAX_MIN  = 8'h59;
  localparam logic [7:0] BCD_MAX_HOUR = 8'h23;
  localparam logic [7:0] BCD_NOON     = 8'h12;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    logic [7:0] r;
    if (v == lim)            r = 8'h00;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                     r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lim);
    logic [7:0] r;
    if (v == 8'h00)          r = lim;
    else if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
    else                     r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  // 00 -> 12, 13..23 -> 01..11, 01..12 unchanged. Done through a small
  // binary value because BCD subtraction of 12 breaks across the 20s.
  function automatic logic [7:0] hour_to_12h(input logic [7:0] hh);
    logic [4:0] bin;
    logic [4:0] adj;
    logic [7:0] r;
    bin = 5'(hh[7:4]) * 5'd10 + 5'(hh[3:0]);
    adj = bin - 5'd12;
    if (hh == 8'h00)         r = BCD_NOON;
    else if (bin >= 5'd13)   r = (adj >= 5'd10) ? {4'd1, 4'(adj - 5'd10)} : {4'd0, adj[3:0]};
    else                     r = hh;
    return r;
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// ---------------------------------------------------------------------------
// bcd_time_counter
// 24-hour BCD hh:mm:ss counter with manual adjust.
//   clk, rst_n          : clock, asynchronous active-low reset
//   tick                : advance one second (carry ss->mm->hh)
//   min_up/min_down     : mm +/-1 with wrap, no carry, ss untouched
//   hour_up/hour_down   : hh +/-1 with wrap
//   time_bcd            : current {hh,mm,ss}
//   time_next           : value time_bcd takes at the next edge
// All adjust inputs are single-cycle pulses; a pulse is consumed in the
// cycle it is high. Presses that land on a tick cycle are parked in the
// pending flags and applied the cycle after, so none is lost.
// ---------------------------------------------------------------------------
module bcd_time_counter
  import clock_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        min_up,
  input  logic        min_down,
  input  logic        hour_up,
  input  logic        hour_down,
  output logic [23:0] time_bcd,
  output logic [23:0] time_next
);

  logic [7:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic [3:0] pend_q, pend_d;  // {min_up, min_down, hour_up, hour_down}
  logic       mu, md, hu, hd;

  always_comb begin
    hh_d   = hh_q;
    mm_d   = mm_q;
    ss_d   = ss_q;
    pend_d = pend_q;
    mu     = min_up    | pend_q[3];
    md     = min_down  | pend_q[2];
    hu     = hour_up   | pend_q[1];
    hd     = hour_down | pend_q[0];
    if (tick) begin
      ss_d = bcd_inc(ss_q, BCD_MAX_MIN);
      if (ss_q == BCD_MAX_MIN) begin
        mm_d = bcd_inc(mm_q, BCD_MAX_MIN);
        if (mm_q == BCD_MAX_MIN) hh_d = bcd_inc(hh_q, BCD_MAX_HOUR);
      end
      pend_d = {mu, md, hu, hd};
    end else begin
      // Up and down together on one field cancel out.
      if (mu && !md)      mm_d = bcd_inc(mm_q, BCD_MAX_MIN);
      else if (md && !mu) mm_d = bcd_dec(mm_q, BCD_MAX_MIN);
      if (hu && !hd)      hh_d = bcd_inc(hh_q, BCD_MAX_HOUR);
      else if (hd && !hu) hh_d = bcd_dec(hh_q, BCD_MAX_HOUR);
      pend_d = 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hh_q   <= 8'h00;
      mm_q   <= 8'h00;
      ss_q   <= 8'h00;
      pend_q <= 4'b0000;
    end else begin
      hh_q   <= hh_d;
      mm_q   <= mm_d;
      ss_q   <= ss_d;
      pend_q <= pend_d;
    end
  end

  assign time_bcd  = {hh_q, mm_q, ss_q};
  assign time_next = {hh_d, mm_d, ss_d};

endmodule

// File: rtl/multi_alarm_clock.sv
// ---------------------------------------------------------------------------
// multi_alarm_clock
// Real-time clock with NUM_ALARMS alarm slots, snooze and ring timeout.
//   clk, reset           : clock, asynchronous active-low reset
//   run                  : time advances while high
//   mode_12h             : 12-hour display select (combinational on outputs)
//   min_up/min_down,
//   hour_up/hour_down    : single-cycle time adjust pulses
//   alarm_sel/alarm_load : copy current hh:mm into slot alarm_sel
//   alarm_en             : per-slot enable
//   snooze, dismiss      : single-cycle pulses (dismiss wins)
//   time_bcd, pm         : displayed {hh,mm,ss} and afternoon flag
//   ringing, ring_src    : ring active and the slot that caused it
//   sec_tick             : one-cycle pulse per elapsed second
//   dbg_state            : current alarm FSM state
// ---------------------------------------------------------------------------
module multi_alarm_clock
  import clock_pkg::*;
#(
  parameter  int CLK_HZ           = 100_000_000,
  parameter  int NUM_ALARMS       = 4,
  parameter  int SNOOZE_MIN       = 5,
  parameter  int RING_TIMEOUT_MIN = 2,
  localparam int SEL_W            = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  mode_12h,
  input  logic                  min_up,
  input  logic                  min_down,
  input  logic                  hour_up,
  input  logic                  hour_down,
  input  logic [SEL_W-1:0]      alarm_sel,
  input  logic                  alarm_load,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic [23:0]           time_bcd,
  output logic                  pm,
  output logic                  ringing,
  output logic [SEL_W-1:0]      ring_src,
  output logic                  sec_tick,
  output logic [1:0]            dbg_state
);

  localparam int         CNT_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);
  localparam logic [11:0] RING_LOAD = 12'(RING_TIMEOUT_MIN * 60);
  localparam logic [11:0] SNZ_LOAD  = 12'(SNOOZE_MIN * 60);

  // ---------------- prescaler ----------------
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign sec_tick = run && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (run) cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
  end

  // ---------------- time of day ----------------
  logic [23:0] cur_time, next_time;

  bcd_time_counter u_time (
    .clk       (clk),
    .rst_n     (reset),
    .tick      (sec_tick),
    .min_up    (min_up),
    .min_down  (min_down),
    .hour_up   (hour_up),
    .hour_down (hour_down),
    .time_bcd  (cur_time),
    .time_next (next_time)
  );

  assign time_bcd = {(mode_12h ? hour_to_12h(cur_time[23:16]) : cur_time[23:16]), cur_time[15:0]};
  assign pm       = mode_12h && (cur_time[23:16] >= BCD_NOON);

  // ---------------- alarm bank ----------------
  logic [15:0]      slot_q [NUM_ALARMS];
  logic [15:0]      slot_d [NUM_ALARMS];
  logic             trig;
  logic [SEL_W-1:0] trig_idx;

  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      slot_d[i] = slot_q[i];
      // Out-of-range selects match no slot and are dropped.
      if (alarm_load && (32'(alarm_sel) == i)) slot_d[i] = cur_time[23:8];
    end
  end

  // Compare against the time being entered this edge so ringing rises on
  // the same edge the display reaches hh:mm:00. Scanning downwards lets the
  // lowest matching index win.
  always_comb begin
    trig     = 1'b0;
    trig_idx = '0;
    if (sec_tick && (next_time[7:0] == 8'h00)) begin
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
        if (alarm_en[i] && (slot_q[i] == next_time[23:8])) begin
          trig     = 1'b1;
          trig_idx = SEL_W'(i);
        end
      end
    end
  end

  // ---------------- ring FSM ----------------
  ring_state_t      state_q, state_d;
  logic [SEL_W-1:0] src_q, src_d;
  logic [11:0]      ring_tmr_q, ring_tmr_d;
  logic [11:0]      snz_tmr_q, snz_tmr_d;

  // Timers count seconds; the transition happens on the tick that takes
  // the timer from 1 to 0.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    ring_tmr_d = ring_tmr_q;
    snz_tmr_d  = snz_tmr_q;
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d    = RINGING;
          src_d      = trig_idx;
          ring_tmr_d = RING_LOAD;
        end
      end
      RINGING: begin
        if (dismiss) begin
          state_d    = IDLE;
          ring_tmr_d = '0;
        end else if (snooze) begin
          state_d    = SNOOZE;
          snz_tmr_d  = SNZ_LOAD;
          ring_tmr_d = '0;
        end else if (sec_tick) begin
          if (ring_tmr_q <= 12'd1) begin
            state_d    = IDLE;
            ring_tmr_d = '0;
          end else begin
            ring_tmr_d = ring_tmr_q - 12'd1;
          end
        end
      end
      SNOOZE: begin
        if (dismiss) begin
          state_d   = IDLE;
          snz_tmr_d = '0;
        end else if (trig) begin
          state_d    = RINGING;
          src_d      = trig_idx;
          ring_tmr_d = RING_LOAD;
          snz_tmr_d  = '0;
        end else if (sec_tick) begin
          if (snz_tmr_q <= 12'd1) begin
            state_d    = RINGING;
            ring_tmr_d = RING_LOAD;
            snz_tmr_d  = '0;
          end else begin
            snz_tmr_d = snz_tmr_q - 12'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      state_q    <= IDLE;
      src_q      <= '0;
      ring_tmr_q <= '0;
      snz_tmr_q  <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) slot_q[i] <= 16'h0000;
    end else begin
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      src_q      <= src_d;
      ring_tmr_q <= ring_tmr_d;
      snz_tmr_q  <= snz_tmr_d;
      for (int i = 0; i < NUM_ALARMS; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign ringing   = (state_q == RINGING);
  assign ring_src  = src_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// ---------------------------------------------------------------------------
// tb_multi_alarm_clock
// Directed bench for multi_alarm_clock with CLK_HZ=10, SNOOZE_MIN=1,
// RING_TIMEOUT_MIN=2. A vector table covers adjust and display modes;
// hand-written sequences cover rollover, pending adjust, alarms, snooze,
// timeout and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_multi_alarm_clock;
  import clock_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        run, mode_12h, min_up, min_down, hour_up, hour_down;
  logic [1:0]  alarm_sel;
  logic        alarm_load;
  logic [3:0]  alarm_en;
  logic        snooze, dismiss;
  logic [23:0] time_bcd;
  logic        pm, ringing, sec_tick;
  logic [1:0]  ring_src;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  multi_alarm_clock #(
    .CLK_HZ           (10),
    .NUM_ALARMS       (4),
    .SNOOZE_MIN       (1),
    .RING_TIMEOUT_MIN (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .mode_12h   (mode_12h),
    .min_up     (min_up),
    .min_down   (min_down),
    .hour_up    (hour_up),
    .hour_down  (hour_down),
    .alarm_sel  (alarm_sel),
    .alarm_load (alarm_load),
    .alarm_en   (alarm_en),
    .snooze     (snooze),
    .dismiss    (dismiss),
    .time_bcd   (time_bcd),
    .pm         (pm),
    .ringing    (ringing),
    .ring_src   (ring_src),
    .sec_tick   (sec_tick),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [24:0] exp_q[$];  // {pm, time_bcd} expected for table vectors

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic adj(input logic mu, input logic md, input logic hu, input logic hd, input int reps);
    min_up = mu; min_down = md; hour_up = hu; hour_down = hd;
    step(reps);
    min_up = 1'b0; min_down = 1'b0; hour_up = 1'b0; hour_down = 1'b0;
    #1;
  endtask

  task automatic load_slot(input logic [1:0] sel);
    alarm_sel = sel; alarm_load = 1'b1;
    step(1);
    alarm_load = 1'b0;
  endtask

  // Run until ringing equals want, counting sec_tick cycles on the way.
  task automatic run_until(input logic want, input int max_cyc, output int ticks, output logic ok);
    ticks = 0; ok = 1'b0;
    run = 1'b1;
    #1;
    for (int i = 0; i < max_cyc; i++) begin
      if (sec_tick) ticks++;
      step(1);
      if (ringing == want) begin
        ok = 1'b1;
        break;
      end
    end
    run = 1'b0;
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [7:0]  reps;
    logic        mode;
    logic        mu, md, hu, hd;
    logic [23:0] exp_time;
    logic        exp_pm;
  } vec_t;

  vec_t vecs [18];

  int   ticks;
  logic ok;

  initial begin
    vecs[0]  = '{8'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000100, 1'b0};
    vecs[1]  = '{8'd1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0};
    vecs[2]  = '{8'd1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h005900, 1'b0};
    vecs[3]  = '{8'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0};
    vecs[4]  = '{8'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h230000, 1'b0};
    vecs[5]  = '{8'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0};
    vecs[6]  = '{8'd1,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0};
    vecs[7]  = '{8'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h120000, 1'b0};
    vecs[8]  = '{8'd30, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h123000, 1'b0};
    vecs[9]  = '{8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h003000, 1'b0};
    vecs[10] = '{8'd25, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h120500, 1'b0};
    vecs[11] = '{8'd13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h010500, 1'b1};
    vecs[12] = '{8'd7,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h080500, 1'b1};
    vecs[13] = '{8'd3,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h110500, 1'b1};
    vecs[14] = '{8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h230500, 1'b0};
    vecs[15] = '{8'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h120500, 1'b1};
    vecs[16] = '{8'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h110500, 1'b0};
    vecs[17] = '{8'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h110500, 1'b0};

    reset = 1'b0; run = 1'b0; mode_12h = 1'b0;
    min_up = 1'b0; min_down = 1'b0; hour_up = 1'b0; hour_down = 1'b0;
    alarm_sel = 2'd0; alarm_load = 1'b0; alarm_en = 4'b0000;
    snooze = 1'b0; dismiss = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);

    // reset state
    check("reset_time", time_bcd, 24'h000000);
    check("reset_ringing", ringing, 1'b0);
    check("reset_src", ring_src, 2'd0);
    check("reset_tick", sec_tick, 1'b0);
    check("reset_state", dbg_state, IDLE);

    // adjust and display table (run=0)
    for (int i = 0; i < 18; i++) begin
      mode_12h = vecs[i].mode;
      exp_q.push_back({vecs[i].exp_pm, vecs[i].exp_time});
      adj(vecs[i].mu, vecs[i].md, vecs[i].hu, vecs[i].hd, int'(vecs[i].reps));
      check($sformatf("vec%0d", i), {pm, time_bcd}, 32'(exp_q.pop_front()));
    end
    mode_12h = 1'b0;

    reset = 1'b0; #2; reset = 1'b1;
    step(1);

    // midnight rollover: 23:59:58 + 20 cycles
    run = 1'b1; step(580); run = 1'b0; #1;
    check("ss58", time_bcd, 24'h000058);
    adj(1'b0, 1'b1, 1'b0, 1'b0, 1);
    adj(1'b0, 1'b0, 1'b0, 1'b1, 1);
    check("pre_rollover", time_bcd, 24'h235958);
    ticks = 0;
    run = 1'b1; #1;
    for (int i = 0; i < 20; i++) begin
      if (sec_tick) ticks++;
      step(1);
    end
    run = 1'b0; #1;
    check("rollover_time", time_bcd, 24'h000000);
    check("rollover_ticks", ticks, 2);

    // min_up landing on a tick at 10:59:59
    adj(1'b0, 1'b0, 1'b1, 1'b0, 10);
    adj(1'b0, 1'b1, 1'b0, 1'b0, 1);
    run = 1'b1; step(599);
    check("pre_pend_time", time_bcd, 24'h105959);
    check("pre_pend_tick", sec_tick, 1'b1);
    min_up = 1'b1; step(1); min_up = 1'b0; run = 1'b0; #1;
    check("pend_tick_time", time_bcd, 24'h110000);
    step(1);
    check("pend_apply_time", time_bcd, 24'h110100);

    // alarm slots: all four at 07:00, slot 0 disabled
    adj(1'b0, 1'b1, 1'b0, 1'b0, 1);
    adj(1'b0, 1'b0, 1'b0, 1'b1, 4);
    check("set_0700", time_bcd, 24'h070000);
    for (int s = 0; s < 4; s++) load_slot(2'(s));
    adj(1'b0, 1'b0, 1'b0, 1'b1, 1);
    adj(1'b0, 1'b1, 1'b0, 1'b0, 1);
    run = 1'b1; step(590); run = 1'b0; #1;
    check("set_065959", time_bcd, 24'h065959);
    alarm_en = 4'b1110;
    run_until(1'b1, 30, ticks, ok);
    check("trig_seen", ok, 1'b1);
    check("trig_ticks", ticks, 1);
    check("trig_time", time_bcd, 24'h070000);
    check("trig_src", ring_src, 2'd1);

    // snooze then re-ring after 60 ticks
    snooze = 1'b1; step(1); snooze = 1'b0; #1;
    check("snooze_ringing", ringing, 1'b0);
    check("snooze_state", dbg_state, SNOOZE);
    run_until(1'b1, 700, ticks, ok);
    check("rering_seen", ok, 1'b1);
    check("rering_ticks", ticks, 60);
    check("rering_time", time_bcd, 24'h070100);
    check("rering_src", ring_src, 2'd1);

    // ring timeout after 120 ticks
    run_until(1'b0, 1300, ticks, ok);
    check("timeout_seen", ok, 1'b1);
    check("timeout_ticks", ticks, 120);
    check("timeout_time", time_bcd, 24'h070300);
    check("timeout_state", dbg_state, IDLE);

    // slot 0 at 07:04, then snooze+dismiss together
    adj(1'b1, 1'b0, 1'b0, 1'b0, 1);
    load_slot(2'd0);
    adj(1'b0, 1'b1, 1'b0, 1'b0, 1);
    alarm_en = 4'b0001;
    run_until(1'b1, 700, ticks, ok);
    check("trig2_seen", ok, 1'b1);
    check("trig2_ticks", ticks, 60);
    check("trig2_src", ring_src, 2'd0);
    snooze = 1'b1; dismiss = 1'b1; step(1); snooze = 1'b0; dismiss = 1'b0; #1;
    check("snz_dis_ringing", ringing, 1'b0);
    check("snz_dis_state", dbg_state, IDLE);

    // adjusting onto an enabled slot does not ring
    adj(1'b1, 1'b0, 1'b0, 1'b0, 1);
    adj(1'b0, 1'b1, 1'b0, 1'b0, 1);
    step(2);
    check("adj_no_trig_time", time_bcd, 24'h070400);
    check("adj_no_trig", ringing, 1'b0);

    // ring again, then asynchronous reset between clock edges
    adj(1'b1, 1'b0, 1'b0, 1'b0, 1);
    load_slot(2'd0);
    adj(1'b0, 1'b1, 1'b0, 1'b0, 1);
    run_until(1'b1, 700, ticks, ok);
    check("trig3_seen", ok, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_ringing", ringing, 1'b0);
    check("arst_time", time_bcd, 24'h000000);
    check("arst_src", ring_src, 2'd0);
    check("arst_tick", sec_tick, 1'b0);
    mode_12h = 1'b1;
    #1;
    check("arst_time_12h", time_bcd, 24'h120000);
    check("arst_pm", pm, 1'b0);
    mode_12h = 1'b0;
    step(1);
    reset = 1'b1;
    step(2);
    check("post_rst_state", dbg_state, IDLE);
    check("post_rst_time", time_bcd, 24'h000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
